microwave_controller: RTL

//  Sequencing FSM for the microwave cook timer (minutes_seconds_counter). Shifts keypad digits

---
 rtl/microwave_controller_if.sv | 43 ++++
 rtl/microwave_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/microwave_controller_if.sv
// Purpose : Signal bundle between the microwave controller and its surroundings
//           (keypad, front-panel buttons, door switch and the cook timer).
// Modports:
//    master - the controller: reads keypad/buttons/door/timer_zero,
//             drives load_data, loadn, timer_en, mag_on, state_o, beep
//    slave  - the environment: the opposite directions
// Signals :
//    key_valid   1  one-cycle strobe, key_digit valid
//    key_digit   4  BCD digit 0-9 (10-15 are ignored by the controller)
//    startn      1  start button, active-low level
//    stopn       1  stop/clear button, active-low level
//    door_closed 1  1 = door closed
//    timer_zero  1  zero flag from the timer
//    load_data   4  digit into the timer load chain
//    loadn       1  one-cycle load/shift strobe (active-high pulse)
//    timer_en    1  one-cycle count-down enable
//    mag_on      1  magnetron drive
//    state_o     3  current controller state
//    beep        1  end-of-cook alarm
interface microwave_controller_if;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       startn;
   logic       stopn;
   logic       door_closed;
   logic       timer_zero;
   logic [3:0] load_data;
   logic       loadn;
   logic       timer_en;
   logic       mag_on;
   logic [2:0] state_o;
   logic       beep;

   modport master (
      input  key_valid, key_digit, startn, stopn, door_closed, timer_zero,
      output load_data, loadn, timer_en, mag_on, state_o, beep
   );

   modport slave (
      output key_valid, key_digit, startn, stopn, door_closed, timer_zero,
      input  load_data, loadn, timer_en, mag_on, state_o, beep
   );
endinterface

// File: rtl/microwave_controller.sv
// Purpose : Sequencing FSM for the microwave cook timer. Shifts keypad digits
//           into the timer load chain, generates the one-second count-down
//           enable, drives the magnetron and reacts to door/stop/start events.
// Ports   :
//    clock  - system clock, all logic on the rising edge
//    clrn   - synchronous active-low reset
//    bus    - microwave_controller_if.master (keypad, buttons, door, timer
//             handshake and status outputs)
// Parameters:
//    TICK_DIV    - clock cycles per timer_en pulse
//    MAX_DIGITS  - keypad digits accepted per entry, also zero-shifts on CLEAR
//    BEEP_CYCLES - beep length on entry to DONE
// Build option:
//    MW_DONE_BEEP_EN - when defined, beep sounds for BEEP_CYCLES cycles on entry
//                      to DONE (or until DONE exits); otherwise beep is tied low.
module microwave_controller #(
   parameter int TICK_DIV    = 100,
   parameter int MAX_DIGITS  = 3,
   parameter int BEEP_CYCLES = 50
) (
   input logic                   clock,
   input logic                   clrn,
   microwave_controller_if.master bus
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DIGITS_MAX = CW'(MAX_DIGITS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4,
      CLEAR = 3'd5
   } state_t;

   state_t        state, next_state;
   logic [PW-1:0] presc, presc_nxt;
   logic [CW-1:0] digit_cnt, digit_cnt_nxt;
   logic [CW-1:0] clr_cnt, clr_cnt_nxt;
   logic [3:0]    load_data_q, load_data_nxt;
   logic          loadn_q, loadn_nxt;
   logic          timer_en_q, timer_en_nxt;
   logic          mag_on_q, mag_on_nxt;
   logic          start_prev, stop_prev;
   logic          start_evt, stop_evt, key_ok;

   // Buttons are levels; an event is the cycle the level first goes low.
   assign start_evt = start_prev & ~bus.startn;
   assign stop_evt  = stop_prev  & ~bus.stopn;
   assign key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);

   // Next-state and next-output decode. Outputs are registered, so every
   // strobe appears the cycle after the event that caused it. Within a state
   // the if/else order encodes the priority stop > door open > start > key.
   always_comb begin
      next_state    = state;
      presc_nxt     = presc;
      digit_cnt_nxt = digit_cnt;
      clr_cnt_nxt   = clr_cnt;
      load_data_nxt = load_data_q;
      loadn_nxt     = 1'b0;
      timer_en_nxt  = 1'b0;

      case (state)
         IDLE, ENTRY: begin
            if (stop_evt) begin
               // First zero-shift is issued on entry so the CLEAR pulses
               // line up with the CLEAR state cycles.
               next_state    = CLEAR;
               load_data_nxt = 4'd0;
               loadn_nxt     = 1'b1;
               clr_cnt_nxt   = CW'(1);
            end else if (start_evt && bus.door_closed && !bus.timer_zero) begin
               next_state = COOK;
               presc_nxt  = '0;
            end else if (key_ok && (digit_cnt < DIGITS_MAX)) begin
               next_state    = ENTRY;
               load_data_nxt = bus.key_digit;
               loadn_nxt     = 1'b1;
               digit_cnt_nxt = digit_cnt + 1'b1;
            end
         end

         COOK: begin
            if (stop_evt || !bus.door_closed) begin
               // Prescaler is left untouched so a resumed cook keeps its phase.
               next_state = PAUSE;
            end else if (bus.timer_zero) begin
               next_state = DONE;
            end else if (presc == PRESC_LAST) begin
               presc_nxt    = '0;
               timer_en_nxt = 1'b1;
            end else begin
               presc_nxt = presc + 1'b1;
            end
         end

         PAUSE: begin
            if (stop_evt) begin
               next_state    = CLEAR;
               load_data_nxt = 4'd0;
               loadn_nxt     = 1'b1;
               clr_cnt_nxt   = CW'(1);
            end else if (start_evt && bus.door_closed) begin
               next_state = COOK;
            end
         end

         DONE: begin
            if (stop_evt || !bus.door_closed || key_ok) begin
               next_state    = IDLE;
               digit_cnt_nxt = '0;
            end
         end

         CLEAR: begin
            if (clr_cnt < DIGITS_MAX) begin
               load_data_nxt = 4'd0;
               loadn_nxt     = 1'b1;
               clr_cnt_nxt   = clr_cnt + 1'b1;
            end else begin
               next_state    = IDLE;
               digit_cnt_nxt = '0;
               clr_cnt_nxt   = '0;
            end
         end

         default: next_state = IDLE;
      endcase

      mag_on_nxt = (next_state == COOK);
   end

   // State, counters, registered outputs and button history.
   always_ff @(posedge clock) begin
      if (!clrn) begin
         state       <= IDLE;
         presc       <= '0;
         digit_cnt   <= '0;
         clr_cnt     <= '0;
         load_data_q <= 4'd0;
         loadn_q     <= 1'b0;
         timer_en_q  <= 1'b0;
         mag_on_q    <= 1'b0;
         start_prev  <= 1'b1;
         stop_prev   <= 1'b1;
      end else begin
         state       <= next_state;
         presc       <= presc_nxt;
         digit_cnt   <= digit_cnt_nxt;
         clr_cnt     <= clr_cnt_nxt;
         load_data_q <= load_data_nxt;
         loadn_q     <= loadn_nxt;
         timer_en_q  <= timer_en_nxt;
         mag_on_q    <= mag_on_nxt;
         start_prev  <= bus.startn;
         stop_prev   <= bus.stopn;
      end
   end

   assign bus.load_data = load_data_q;
   assign bus.loadn     = loadn_q;
   assign bus.timer_en  = timer_en_q;
   assign bus.mag_on    = mag_on_q;
   assign bus.state_o   = state;

`ifdef MW_DONE_BEEP_EN
   localparam int BW = $clog2(BEEP_CYCLES + 1);

   logic [BW-1:0] beep_cnt;
   logic          beep_q;

   // beep_cnt counts cycles already sounded; the alarm drops when it reaches
   // BEEP_CYCLES or as soon as the FSM leaves DONE.
   always_ff @(posedge clock) begin
      if (!clrn) begin
         beep_q   <= 1'b0;
         beep_cnt <= '0;
      end else if ((next_state == DONE) && (state != DONE)) begin
         beep_q   <= (BEEP_CYCLES > 0);
         beep_cnt <= BW'(1);
      end else if ((next_state == DONE) && beep_q && (beep_cnt < BW'(BEEP_CYCLES))) begin
         beep_cnt <= beep_cnt + 1'b1;
      end else begin
         beep_q <= 1'b0;
      end
   end

   assign bus.beep = beep_q;
`else
   // Alarm not built: the comparison is constant-false and only keeps
   // BEEP_CYCLES referenced in this configuration.
   assign bus.beep = (BEEP_CYCLES < 0);
`endif

endmodule
